// File: rtl/sys_defs.sv
// Shared definitions for the completion stage.
// Holds the default datapath widths, the data-memory bus command and size
// encodings, the completion FSM state type and the completion-queue entry.
package sys_defs;

    localparam int SYS_XLEN      = 32;
    localparam int SYS_PRF_IDX_W = 6;
    localparam int SYS_ROB_IDX_W = 5;

    // Data-memory bus commands
    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;

    typedef enum logic [1:0] {
        BYTE = 2'h0,
        HALF = 2'h1,
        WORD = 2'h2
    } MEM_SIZE;

    typedef enum logic {
        RUN        = 1'b0,
        STORE_WAIT = 1'b1
    } CMPL_STATE;

    // One execute result waiting to retire
    typedef struct packed {
        logic [SYS_XLEN-1:0]      result;      // ALU result or store address
        logic [SYS_XLEN-1:0]      rs2_value;   // store data
        logic [1:0]               mem_size;
        logic                     wr_mem;
        logic [SYS_PRF_IDX_W-1:0] dest_tag;
        logic [SYS_ROB_IDX_W-1:0] rob_idx;
        logic                     take_branch;
        logic [SYS_XLEN-1:0]      npc;
        logic                     halt;
        logic                     illegal;
    } IC_ENTRY;

endpackage

// File: rtl/ic_queue.sv
// In-order circular FIFO of completion entries.
// Ports: clock/reset (sync, active-high), flush (clears like reset),
//   push/wr_entry (write at tail, ignored when full), pop (advance head,
//   ignored when empty), head_entry (entry at head), empty, full, count.
module ic_queue #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  entry_t           wr_entry,
    input  logic             pop,
    output entry_t           head_entry,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;
    assign head_entry = mem_q[head_q];
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (!(reset || flush) && do_push) mem_q[tail_q] <= wr_entry;
    end

endmodule

// File: rtl/stage_complete.sv
// Completion stage: queues execute results in order and retires one per
// cycle, broadcasting on the CDB, performing stores through a two-state
// handshake with data memory, and marking ROB entries complete.
// Ports: clock/reset (sync, active-high), squash (clears everything),
//   ex_* (execute result in), ic_ready (backpressure out), cdb_* (tag
//   broadcast), rob_* (completion report), st2Dmem_*/Dmem2st_ack (store bus).
// Width parameters must match the sys_defs defaults because the queue entry
// type is defined there.
module stage_complete
    import sys_defs::*;
#(
    parameter int XLEN      = SYS_XLEN,
    parameter int DEPTH     = 4,
    parameter int PRF_IDX_W = SYS_PRF_IDX_W,
    parameter int ROB_IDX_W = SYS_ROB_IDX_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic                 ex_valid,
    input  logic [XLEN-1:0]      ex_result,
    input  logic [XLEN-1:0]      ex_rs2_value,
    input  logic [1:0]           ex_mem_size,
    input  logic                 ex_wr_mem,
    input  logic [PRF_IDX_W-1:0] ex_dest_tag,
    input  logic [ROB_IDX_W-1:0] ex_rob_idx,
    input  logic                 ex_take_branch,
    input  logic [XLEN-1:0]      ex_npc,
    input  logic                 ex_halt,
    input  logic                 ex_illegal,
    output logic                 ic_ready,
    output logic                 cdb_valid,
    output logic [PRF_IDX_W-1:0] cdb_tag,
    output logic [XLEN-1:0]      cdb_data,
    output logic                 rob_complete_en,
    output logic [ROB_IDX_W-1:0] rob_complete_idx,
    output logic                 rob_take_branch,
    output logic                 rob_halt,
    output logic                 rob_illegal,
    output logic [1:0]           st2Dmem_command,
    output logic [XLEN-1:0]      st2Dmem_addr,
    output logic [XLEN-1:0]      st2Dmem_data,
    output logic [1:0]           st2Dmem_size,
    input  logic                 Dmem2st_ack
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    IC_ENTRY          wr_entry, head;
    logic             q_empty, q_full, flush, push, pop;
    logic [CNT_W-1:0] q_count;
    CMPL_STATE        state_q, state_d;

    assign flush = reset || squash;
    // Readiness comes only from registered count, so a full queue stays
    // not-ready even in a cycle where it pops.
    assign ic_ready = (q_count < CNT_W'(DEPTH));
    assign push     = ex_valid && ic_ready && !flush;

    always_comb begin
        wr_entry             = '0;
        wr_entry.result      = ex_result;
        wr_entry.rs2_value   = ex_rs2_value;
        wr_entry.mem_size    = ex_mem_size;
        wr_entry.wr_mem      = ex_wr_mem;
        wr_entry.dest_tag    = ex_dest_tag;
        wr_entry.rob_idx     = ex_rob_idx;
        wr_entry.take_branch = ex_take_branch;
        wr_entry.npc         = ex_npc;
        wr_entry.halt        = ex_halt;
        wr_entry.illegal     = ex_illegal;
    end

    ic_queue #(.DEPTH(DEPTH), .entry_t(IC_ENTRY)) u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (squash),
        .push       (push),
        .wr_entry   (wr_entry),
        .pop        (pop),
        .head_entry (head),
        .empty      (q_empty),
        .full       (q_full),
        .count      (q_count)
    );

    always_comb begin
        state_d          = state_q;
        pop              = 1'b0;
        cdb_valid        = 1'b0;
        cdb_tag          = '0;
        cdb_data         = '0;
        rob_complete_en  = 1'b0;
        rob_complete_idx = '0;
        rob_take_branch  = 1'b0;
        rob_halt         = 1'b0;
        rob_illegal      = 1'b0;
        st2Dmem_command  = BUS_NONE;
        st2Dmem_addr     = '0;
        st2Dmem_data     = '0;
        st2Dmem_size     = '0;
        if (!q_empty) begin
            if (head.wr_mem) begin
                // Store fields are held from the request cycle until ack.
                st2Dmem_command = BUS_STORE;
                st2Dmem_addr    = head.result;
                st2Dmem_data    = head.rs2_value;
                st2Dmem_size    = head.mem_size;
            end
            case (state_q)
                RUN: begin
                    if (head.wr_mem) begin
                        state_d = STORE_WAIT;
                    end else begin
                        pop       = 1'b1;
                        cdb_valid = (head.dest_tag != '0) && !head.illegal;
                        if (cdb_valid) begin
                            cdb_tag  = head.dest_tag;
                            cdb_data = head.take_branch ? head.npc : head.result;
                        end
                    end
                end
                STORE_WAIT: begin
                    if (Dmem2st_ack) begin
                        pop     = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
            if (pop) begin
                rob_complete_en  = 1'b1;
                rob_complete_idx = head.rob_idx;
                rob_take_branch  = head.take_branch;
                rob_halt         = head.halt;
                rob_illegal      = head.illegal;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (flush) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Upstream must honour ic_ready; an entry offered while full is lost.
    always @(posedge clock) begin
        if (!flush && ex_valid) assert (!q_full);
    end

endmodule

// File: tb/tb_stage_complete.sv
module tb_stage_complete;

    logic        clock = 1'b0;
    logic        reset, squash, ex_valid;
    logic [31:0] ex_result, ex_rs2_value, ex_npc;
    logic [1:0]  ex_mem_size;
    logic        ex_wr_mem, ex_take_branch, ex_halt, ex_illegal;
    logic [5:0]  ex_dest_tag;
    logic [4:0]  ex_rob_idx;
    logic        ic_ready, cdb_valid, rob_complete_en, rob_take_branch, rob_halt, rob_illegal;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data, st2Dmem_addr, st2Dmem_data;
    logic [4:0]  rob_complete_idx;
    logic [1:0]  st2Dmem_command, st2Dmem_size;
    logic        Dmem2st_ack;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    stage_complete #(.XLEN(32), .DEPTH(4), .PRF_IDX_W(6), .ROB_IDX_W(5)) dut (
        .clock(clock), .reset(reset), .squash(squash), .ex_valid(ex_valid),
        .ex_result(ex_result), .ex_rs2_value(ex_rs2_value), .ex_mem_size(ex_mem_size),
        .ex_wr_mem(ex_wr_mem), .ex_dest_tag(ex_dest_tag), .ex_rob_idx(ex_rob_idx),
        .ex_take_branch(ex_take_branch), .ex_npc(ex_npc), .ex_halt(ex_halt),
        .ex_illegal(ex_illegal), .ic_ready(ic_ready), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .rob_complete_en(rob_complete_en),
        .rob_complete_idx(rob_complete_idx), .rob_take_branch(rob_take_branch),
        .rob_halt(rob_halt), .rob_illegal(rob_illegal),
        .st2Dmem_command(st2Dmem_command), .st2Dmem_addr(st2Dmem_addr),
        .st2Dmem_data(st2Dmem_data), .st2Dmem_size(st2Dmem_size),
        .Dmem2st_ack(Dmem2st_ack)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #2;
    endtask

    task automatic idle();
        ex_valid = 0; ex_result = 0; ex_rs2_value = 0; ex_mem_size = 0;
        ex_wr_mem = 0; ex_dest_tag = 0; ex_rob_idx = 0; ex_take_branch = 0;
        ex_npc = 0; ex_halt = 0; ex_illegal = 0;
    endtask

    task automatic push(input logic [31:0] res, input logic [31:0] rs2, input logic [1:0] sz,
                        input logic wm, input logic [5:0] tag, input logic [4:0] rob,
                        input logic tb, input logic [31:0] npc, input logic h, input logic il);
        ex_valid = 1; ex_result = res; ex_rs2_value = rs2; ex_mem_size = sz;
        ex_wr_mem = wm; ex_dest_tag = tag; ex_rob_idx = rob; ex_take_branch = tb;
        ex_npc = npc; ex_halt = h; ex_illegal = il;
    endtask

    task automatic test_reset();
        reset = 1; squash = 0; Dmem2st_ack = 0; idle();
        tick(); tick();
        reset = 0; settle();
        checks++; if (ic_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ic_ready); end
        checks++; if ({cdb_valid, rob_complete_en} !== 2'b00) begin errors++; $display("FAIL reset_idle: got cdb=%b rob=%b want 0 0", cdb_valid, rob_complete_en); end
        checks++; if (st2Dmem_command !== 2'h0) begin errors++; $display("FAIL reset_bus: got %0h want 0", st2Dmem_command); end
        tick();
    endtask

    task automatic test_alu();
        push(32'h1234, 0, 2'h2, 0, 6'd5, 5'd3, 0, 32'h4, 0, 0);
        tick(); idle(); settle();
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd5) begin errors++; $display("FAIL alu_cdb: got v=%b tag=%0d want 1 5", cdb_valid, cdb_tag); end
        checks++; if (cdb_data !== 32'h1234) begin errors++; $display("FAIL alu_data: got %h want 00001234", cdb_data); end
        checks++; if (rob_complete_en !== 1'b1 || rob_complete_idx !== 5'd3 || rob_take_branch !== 1'b0) begin errors++; $display("FAIL alu_rob: got en=%b idx=%0d br=%b want 1 3 0", rob_complete_en, rob_complete_idx, rob_take_branch); end
        tick(); settle();
        checks++; if (cdb_valid !== 1'b0 || rob_complete_en !== 1'b0 || cdb_data !== 32'h0) begin errors++; $display("FAIL alu_idle: got cdb=%b rob=%b data=%h want 0 0 0", cdb_valid, rob_complete_en, cdb_data); end
    endtask

    task automatic test_branch_halt_illegal();
        push(32'h999, 0, 2'h2, 0, 6'd1, 5'd4, 1, 32'h104, 0, 0);
        tick();
        push(32'h55, 0, 2'h2, 0, 6'd7, 5'd5, 0, 32'h0, 0, 1);  // illegal
        settle();
        checks++; if (cdb_data !== 32'h104 || rob_take_branch !== 1'b1) begin errors++; $display("FAIL branch: got data=%h br=%b want 00000104 1", cdb_data, rob_take_branch); end
        tick();
        push(32'h66, 0, 2'h2, 0, 6'd0, 5'd6, 0, 32'h0, 1, 0);  // halt, no dest
        settle();
        checks++; if (rob_complete_en !== 1'b1 || rob_illegal !== 1'b1 || cdb_valid !== 1'b0 || rob_complete_idx !== 5'd5) begin errors++; $display("FAIL illegal: got en=%b il=%b cdb=%b idx=%0d want 1 1 0 5", rob_complete_en, rob_illegal, cdb_valid, rob_complete_idx); end
        tick(); idle(); settle();
        checks++; if (rob_complete_en !== 1'b1 || rob_halt !== 1'b1 || cdb_valid !== 1'b0 || rob_complete_idx !== 5'd6) begin errors++; $display("FAIL halt: got en=%b h=%b cdb=%b idx=%0d want 1 1 0 6", rob_complete_en, rob_halt, cdb_valid, rob_complete_idx); end
        tick();
    endtask

    task automatic test_store();
        push(32'h200, 32'hdeadbeef, 2'h2, 1, 6'd0, 5'd6, 0, 32'h0, 0, 0);
        tick(); idle();
        for (int c = 0; c < 4; c++) begin
            Dmem2st_ack = (c == 3);
            settle();
            checks++; if (st2Dmem_command !== 2'h2 || st2Dmem_addr !== 32'h200 || st2Dmem_data !== 32'hdeadbeef || st2Dmem_size !== 2'h2) begin errors++; $display("FAIL store_hold c%0d: got cmd=%0h a=%h d=%h s=%0h want 2 200 deadbeef 2", c, st2Dmem_command, st2Dmem_addr, st2Dmem_data, st2Dmem_size); end
            checks++; if (rob_complete_en !== (c == 3) || cdb_valid !== 1'b0) begin errors++; $display("FAIL store_cmpl c%0d: got en=%b cdb=%b want %b 0", c, rob_complete_en, cdb_valid, c == 3); end
            tick();
        end
        Dmem2st_ack = 0; settle();
        checks++; if (st2Dmem_command !== 2'h0 || rob_complete_en !== 1'b0) begin errors++; $display("FAIL store_done: got cmd=%0h en=%b want 0 0", st2Dmem_command, rob_complete_en); end
        // Ack offered in the request cycle must be ignored.
        push(32'h300, 32'h11, 2'h0, 1, 6'd0, 5'd9, 0, 32'h0, 0, 0);
        tick(); idle(); Dmem2st_ack = 1; settle();
        checks++; if (rob_complete_en !== 1'b0 || st2Dmem_command !== 2'h2) begin errors++; $display("FAIL store_early_ack: got en=%b cmd=%0h want 0 2", rob_complete_en, st2Dmem_command); end
        tick(); settle();
        checks++; if (rob_complete_en !== 1'b1 || rob_complete_idx !== 5'd9 || st2Dmem_size !== 2'h0) begin errors++; $display("FAIL store_ack: got en=%b idx=%0d sz=%0h want 1 9 0", rob_complete_en, rob_complete_idx, st2Dmem_size); end
        tick(); Dmem2st_ack = 0;
    endtask

    task automatic test_fill();
        push(32'h400, 32'h77, 2'h2, 1, 6'd0, 5'd8, 0, 32'h0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            push(32'h500 + i, 0, 2'h2, 0, 6'(10 + i), 5'(9 + i), 0, 32'h0, 0, 0);
            settle();
            checks++; if (ic_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", i, ic_ready); end
            tick();
        end
        idle(); settle();
        checks++; if (ic_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b want 0", ic_ready); end
        Dmem2st_ack = 1; settle();
        checks++; if (rob_complete_en !== 1'b1 || rob_complete_idx !== 5'd8 || ic_ready !== 1'b0) begin errors++; $display("FAIL fill_ack: got en=%b idx=%0d rdy=%b want 1 8 0", rob_complete_en, rob_complete_idx, ic_ready); end
        tick(); Dmem2st_ack = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (rob_complete_en !== 1'b1 || rob_complete_idx !== 5'(9 + i) || cdb_tag !== 6'(10 + i) || cdb_data !== 32'h500 + i || ic_ready !== 1'b1) begin errors++; $display("FAIL fill_drain%0d: got en=%b idx=%0d tag=%0d data=%h rdy=%b", i, rob_complete_en, rob_complete_idx, cdb_tag, cdb_data, ic_ready); end
            tick();
        end
        settle();
        checks++; if (rob_complete_en !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", rob_complete_en); end
    endtask

    task automatic test_wrap();
        push(32'h100, 0, 2'h2, 0, 6'd1, 5'd16, 0, 32'h0, 0, 0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            push(32'h100 + i, 0, 2'h2, 0, 6'(i + 1), 5'(16 + i), 0, 32'h0, 0, 0);
            settle();
            checks++; if (rob_complete_en !== 1'b1 || rob_complete_idx !== 5'(15 + i) || cdb_data !== 32'h100 + i - 1 || cdb_tag !== 6'(i) || ic_ready !== 1'b1) begin errors++; $display("FAIL wrap%0d: got en=%b idx=%0d data=%h tag=%0d rdy=%b", i, rob_complete_en, rob_complete_idx, cdb_data, cdb_tag, ic_ready); end
            tick();
        end
        idle(); settle();
        checks++; if (rob_complete_idx !== 5'd24 || cdb_data !== 32'h108) begin errors++; $display("FAIL wrap_last: got idx=%0d data=%h want 24 00000108", rob_complete_idx, cdb_data); end
        tick(); settle();
        checks++; if (rob_complete_en !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b want 0", rob_complete_en); end
    endtask

    // use_reset selects reset instead of squash as the clearing event.
    task automatic test_clear(input logic use_reset);
        push(32'h600, 32'h88, 2'h2, 1, 6'd0, 5'd1, 0, 32'h0, 0, 0);
        tick();
        push(32'h601, 0, 2'h2, 0, 6'd3, 5'd2, 0, 32'h0, 0, 0);
        tick();
        push(32'h602, 0, 2'h2, 0, 6'd4, 5'd3, 0, 32'h0, 0, 0);
        tick();
        push(32'h603, 0, 2'h2, 0, 6'd5, 5'd30, 0, 32'h0, 0, 0);
        if (use_reset) reset = 1; else squash = 1;
        settle();
        checks++; if (st2Dmem_command !== 2'h2) begin errors++; $display("FAIL clear%0d_pre: got cmd=%0h want 2", use_reset, st2Dmem_command); end
        tick();
        reset = 0; squash = 0; idle(); settle();
        checks++; if (st2Dmem_command !== 2'h0 || rob_complete_en !== 1'b0 || cdb_valid !== 1'b0 || ic_ready !== 1'b1) begin errors++; $display("FAIL clear%0d: got cmd=%0h en=%b cdb=%b rdy=%b want 0 0 0 1", use_reset, st2Dmem_command, rob_complete_en, cdb_valid, ic_ready); end
        tick(); settle();
        checks++; if (rob_complete_en !== 1'b0 || cdb_valid !== 1'b0) begin errors++; $display("FAIL clear%0d_drop: got en=%b cdb=%b want 0 0", use_reset, rob_complete_en, cdb_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch_halt_illegal();
        test_store();
        test_fill();
        test_wrap();
        test_clear(1'b0);
        test_clear(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
